// File: rtl/nivel_cxa_monitor.sv
// Tank-level monitor: synchronises, debounces and validates N_SENS thermometer-coded float sensors,
// then drives level/fault/alarm flags and a blinking 7-seg display. Optional macro: NIVEL_CXA_STICKY_FAULT_EN.
module nivel_cxa_monitor #(
  parameter int N_SENS         = 3,
  parameter int DEB_CYCLES     = 1000,
  parameter int BLINK_HALF     = 25000000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [N_SENS-1:0]           NV,
  output logic [$clog2(N_SENS+1)-1:0] LEVEL,
  output logic                        LEVEL_VLD,
  output logic                        FAULT,
  output logic                        ALARM_LOW,
  output logic                        SEG_A,
  output logic                        SEG_B,
  output logic                        SEG_C,
  output logic                        SEG_D,
  output logic                        SEG_E,
  output logic                        SEG_F,
  output logic                        SEG_G,
  output logic                        SEG_P
);

  localparam int LW    = $clog2(N_SENS + 1);
  localparam int CW    = $clog2(DEB_CYCLES + 1);
  localparam int BW    = $clog2(BLINK_HALF);
  localparam int CLR_K = (N_SENS < 2) ? N_SENS : 2;

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEB_SAT    = CW'(DEB_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_NORMAL = 2'd1;
  localparam logic [1:0] S_LOW    = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  // Segment patterns are ordered {a,b,c,d,e,f,g}.
  localparam logic [6:0] PAT_DASH  = 7'b0000001;
  localparam logic [6:0] PAT_F     = 7'b1000111;
  localparam logic [6:0] PAT_BLANK = 7'b0000000;

  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0:    digit_pat = 7'b1111110;
      4'd1:    digit_pat = 7'b0110000;
      4'd2:    digit_pat = 7'b1101101;
      4'd3:    digit_pat = 7'b1111001;
      4'd4:    digit_pat = 7'b0110011;
      4'd5:    digit_pat = 7'b1011011;
      4'd6:    digit_pat = 7'b1011111;
      4'd7:    digit_pat = 7'b1110000;
      4'd8:    digit_pat = 7'b1111111;
      4'd9:    digit_pat = 7'b1111011;
      default: digit_pat = PAT_BLANK;
    endcase
  endfunction

  logic [N_SENS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_SENS-1:0] cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     level_q, level_d;
  logic              vld_q, vld_d;
  logic              fault_q, fault_d;
  logic              alarm_q, alarm_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_off_q, blink_off_d;
  logic [7:0]        seg_q, seg_d;

  logic              commit;
  logic              code_valid;
  logic [LW-1:0]     code_k;

  // Debounce: cand tracks the synced vector; the counter saturates one past the commit point.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    sync1_d = NV;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = (cnt_q == DEB_LAST);
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != DEB_SAT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // A thermometer code has no bit set above a zero: x & (x+1) clears only a run of ones at the bottom.
  always_comb begin
    code_k = '0;
    for (int i = 0; i < N_SENS; i++) begin
      code_k = code_k + LW'(cand_q[i]);
    end
    code_valid = ((cand_q & (cand_q + N_SENS'(1))) == '0);
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    vld_d   = vld_q;
    fault_d = fault_q;
    alarm_d = alarm_q;
    if (commit) begin
      if (code_valid) begin
        level_d = code_k;
        vld_d   = 1'b1;
        if (code_k == '0) begin
          alarm_d = 1'b1;
        end else if (code_k >= LW'(CLR_K)) begin
          alarm_d = 1'b0;
        end
`ifdef NIVEL_CXA_STICKY_FAULT_EN
        if (state_q != S_FAULT) begin
          state_d = (code_k == '0) ? S_LOW : S_NORMAL;
        end
`else
        state_d = (code_k == '0) ? S_LOW : S_NORMAL;
        fault_d = 1'b0;
`endif
      end else begin
        state_d = S_FAULT;
        fault_d = 1'b1;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    blink_off_d = blink_off_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_off_d = ~blink_off_q;
    end
  end

  // Display is built from next-state values so it lands on the same edge as LEVEL and the flags.
  always_comb begin
    seg_d = '0;
    case (state_d)
      S_INIT:   seg_d = {PAT_DASH, 1'b0};
      S_NORMAL: seg_d = {digit_pat(4'(level_d)), alarm_d};
      S_LOW:    seg_d = {blink_off_d ? PAT_BLANK : digit_pat(4'd0), alarm_d};
      S_FAULT:  seg_d = {blink_off_d ? PAT_BLANK : PAT_F, alarm_d};
      default:  seg_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      state_q     <= S_INIT;
      level_q     <= '0;
      vld_q       <= 1'b0;
      fault_q     <= 1'b0;
      alarm_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      seg_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge values, modelling real registers.
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      level_q     <= level_d;
      vld_q       <= vld_d;
      fault_q     <= fault_d;
      alarm_q     <= alarm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      seg_q       <= seg_d;
    end
  end

  assign LEVEL     = level_q;
  assign LEVEL_VLD = vld_q;
  assign FAULT     = fault_q;
  assign ALARM_LOW = alarm_q;
  assign {SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P} = seg_q ^ {8{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_nivel_cxa_monitor.sv
// Directed bench for nivel_cxa_monitor (N_SENS=3, DEB_CYCLES=4, BLINK_HALF=8); a second instance
// with SEG_ACTIVE_LOW=1 shares all inputs so its segments can be compared against the inverse.
module tb_nivel_cxa_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] nv;

  logic [1:0] level, level_al;
  logic       level_vld, fault, alarm_low;
  logic       level_vld_al, fault_al, alarm_low_al;
  logic       sa, sb, sc, sd, se, sf, sg, sp;
  logic       la, lb, lc, ld, le, lf, lg, lp;
  logic [7:0] seg, seg_al;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Expected {a,b,c,d,e,f,g,p} patterns with the decimal point clear.
  localparam logic [7:0] E_DASH = 8'b00000010;
  localparam logic [7:0] E_D0   = 8'b11111100;
  localparam logic [7:0] E_D1   = 8'b01100000;
  localparam logic [7:0] E_D2   = 8'b11011010;
  localparam logic [7:0] E_D3   = 8'b11110010;
  localparam logic [7:0] E_F    = 8'b10001110;

  always #5 clk = ~clk;

  nivel_cxa_monitor #(.N_SENS(3), .DEB_CYCLES(4), .BLINK_HALF(8), .SEG_ACTIVE_LOW(1'b0)) dut (
    .CLK(clk), .RST_N(rst_n), .NV(nv),
    .LEVEL(level), .LEVEL_VLD(level_vld), .FAULT(fault), .ALARM_LOW(alarm_low),
    .SEG_A(sa), .SEG_B(sb), .SEG_C(sc), .SEG_D(sd), .SEG_E(se), .SEG_F(sf), .SEG_G(sg), .SEG_P(sp)
  );

  nivel_cxa_monitor #(.N_SENS(3), .DEB_CYCLES(4), .BLINK_HALF(8), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .CLK(clk), .RST_N(rst_n), .NV(nv),
    .LEVEL(level_al), .LEVEL_VLD(level_vld_al), .FAULT(fault_al), .ALARM_LOW(alarm_low_al),
    .SEG_A(la), .SEG_B(lb), .SEG_C(lc), .SEG_D(ld), .SEG_E(le), .SEG_F(lf), .SEG_G(lg), .SEG_P(lp)
  );

  assign seg    = {sa, sb, sc, sd, se, sf, sg, sp};
  assign seg_al = {la, lb, lc, ld, le, lf, lg, lp};

  // Cycles since reset release; the blink phase is OFF during the odd groups of 8.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] blink_exp(input logic [7:0] shown, input logic p);
    if (((cyc / 8) % 2) == 1) return {7'b0, p};
    return shown | {7'b0, p};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    nv    = 3'b011;
    step(2);
    checks++; if (level !== 2'd0)   begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
    checks++; if (level_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", level_vld); end
    checks++; if (fault !== 1'b0)   begin errors++; $display("FAIL reset_fault: got %b exp 0", fault); end
    checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b exp 0", alarm_low); end
    checks++; if (seg !== 8'h00)    begin errors++; $display("FAIL reset_seg: got %b exp 00000000", seg); end
    checks++; if (seg_al !== 8'hFF) begin errors++; $display("FAIL reset_seg_al: got %b exp 11111111", seg_al); end
  endtask

  task automatic test_power_up;
    rst_n = 1'b1;
    step(6);
    checks++; if (level_vld !== 1'b0) begin errors++; $display("FAIL pu_vld_early: got %b exp 0", level_vld); end
    checks++; if (seg !== E_DASH)   begin errors++; $display("FAIL pu_dash: got %b exp %b", seg, E_DASH); end
    checks++; if (seg_al !== ~E_DASH) begin errors++; $display("FAIL pu_dash_al: got %b exp %b", seg_al, ~E_DASH); end
    step(1);
    checks++; if (level !== 2'd2)   begin errors++; $display("FAIL pu_level: got %0d exp 2", level); end
    checks++; if (level_vld !== 1'b1) begin errors++; $display("FAIL pu_vld: got %b exp 1", level_vld); end
    checks++; if (fault !== 1'b0 || alarm_low !== 1'b0) begin
      errors++; $display("FAIL pu_flags: got fault=%b alarm=%b exp 0 0", fault, alarm_low);
    end
    checks++; if (seg !== E_D2)     begin errors++; $display("FAIL pu_digit2: got %b exp %b", seg, E_D2); end
    checks++; if (seg_al !== ~E_D2) begin errors++; $display("FAIL pu_digit2_al: got %b exp %b", seg_al, ~E_D2); end
    step(9);
    checks++; if (seg !== E_D2)     begin errors++; $display("FAIL pu_steady: got %b exp %b", seg, E_D2); end
  endtask

  task automatic test_glitch;
    nv = 3'b001;
    step(3);
    nv = 3'b011;
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (level !== 2'd2 || level_vld !== 1'b1) begin
        errors++; $display("FAIL glitch_hold[%0d]: got level=%0d vld=%b exp 2 1", i, level, level_vld);
      end
    end
  endtask

  task automatic test_low_alarm;
    nv = 3'b000;
    step(6);
    checks++; if (level !== 2'd2)   begin errors++; $display("FAIL low_early: got %0d exp 2", level); end
    step(1);
    checks++; if (level !== 2'd0)   begin errors++; $display("FAIL low_level: got %0d exp 0", level); end
    checks++; if (alarm_low !== 1'b1) begin errors++; $display("FAIL low_alarm: got %b exp 1", alarm_low); end
    checks++; if (sp !== 1'b1)      begin errors++; $display("FAIL low_dp: got %b exp 1", sp); end
    for (int i = 0; i < 16; i++) begin
      step(1);
      checks++;
      if (seg !== blink_exp(E_D0, 1'b1)) begin
        errors++; $display("FAIL low_blink[%0d]: got %b exp %b", i, seg, blink_exp(E_D0, 1'b1));
      end
    end
    nv = 3'b001;
    step(7);
    checks++; if (level !== 2'd1)   begin errors++; $display("FAIL one_level: got %0d exp 1", level); end
    checks++; if (alarm_low !== 1'b1) begin errors++; $display("FAIL one_alarm_hold: got %b exp 1", alarm_low); end
    checks++; if (seg !== (E_D1 | 8'h01)) begin errors++; $display("FAIL one_seg: got %b exp %b", seg, E_D1 | 8'h01); end
    nv = 3'b011;
    step(7);
    checks++; if (level !== 2'd2)   begin errors++; $display("FAIL two_level: got %0d exp 2", level); end
    checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL two_alarm_clr: got %b exp 0", alarm_low); end
    checks++; if (seg !== E_D2)     begin errors++; $display("FAIL two_seg: got %b exp %b", seg, E_D2); end
  endtask

  task automatic test_fault;
    nv = 3'b101;
    step(7);
    checks++; if (fault !== 1'b1)   begin errors++; $display("FAIL flt_fault: got %b exp 1", fault); end
    checks++; if (level !== 2'd2 || level_vld !== 1'b1) begin
      errors++; $display("FAIL flt_level_hold: got level=%0d vld=%b exp 2 1", level, level_vld);
    end
    checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL flt_alarm: got %b exp 0", alarm_low); end
    for (int i = 0; i < 16; i++) begin
      step(1);
      checks++;
      if (seg !== blink_exp(E_F, 1'b0)) begin
        errors++; $display("FAIL flt_blink[%0d]: got %b exp %b", i, seg, blink_exp(E_F, 1'b0));
      end
    end
    nv = 3'b111;
    step(7);
    checks++; if (level !== 2'd3)   begin errors++; $display("FAIL rec_level: got %0d exp 3", level); end
`ifdef NIVEL_CXA_STICKY_FAULT_EN
    checks++; if (fault !== 1'b1)   begin errors++; $display("FAIL rec_fault_sticky: got %b exp 1", fault); end
    checks++; if (seg !== blink_exp(E_F, 1'b0)) begin
      errors++; $display("FAIL rec_seg_sticky: got %b exp %b", seg, blink_exp(E_F, 1'b0));
    end
`else
    checks++; if (fault !== 1'b0)   begin errors++; $display("FAIL rec_fault: got %b exp 0", fault); end
    checks++; if (seg !== E_D3)     begin errors++; $display("FAIL rec_seg: got %b exp %b", seg, E_D3); end
`endif
  endtask

  task automatic test_reset_mid_debounce;
    nv = 3'b001;
    step(4);
    rst_n = 1'b0;
    #1;
    checks++; if (level !== 2'd0 || level_vld !== 1'b0) begin
      errors++; $display("FAIL mid_level: got level=%0d vld=%b exp 0 0", level, level_vld);
    end
    checks++; if (fault !== 1'b0 || alarm_low !== 1'b0) begin
      errors++; $display("FAIL mid_flags: got fault=%b alarm=%b exp 0 0", fault, alarm_low);
    end
    checks++; if (seg !== 8'h00)    begin errors++; $display("FAIL mid_seg: got %b exp 00000000", seg); end
    checks++; if (seg_al !== 8'hFF) begin errors++; $display("FAIL mid_seg_al: got %b exp 11111111", seg_al); end
    step(2);
    rst_n = 1'b1;
    step(6);
    checks++; if (level_vld !== 1'b0) begin errors++; $display("FAIL mid_no_early: got %b exp 0", level_vld); end
    checks++; if (seg !== E_DASH)   begin errors++; $display("FAIL mid_dash: got %b exp %b", seg, E_DASH); end
    step(1);
    checks++; if (level !== 2'd1 || level_vld !== 1'b1) begin
      errors++; $display("FAIL mid_commit: got level=%0d vld=%b exp 1 1", level, level_vld);
    end
    checks++; if (alarm_low !== 1'b0) begin errors++; $display("FAIL mid_alarm: got %b exp 0", alarm_low); end
    checks++; if (seg !== E_D1)     begin errors++; $display("FAIL mid_seg1: got %b exp %b", seg, E_D1); end
    checks++; if (seg_al !== ~E_D1) begin errors++; $display("FAIL mid_seg1_al: got %b exp %b", seg_al, ~E_D1); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_low_alarm();
    test_fault();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
